// File: rtl/iec_pkg.sv
// iec_pkg: IEC bus command codes and decoder state encoding shared by the
// command decoder and its bench.
package iec_pkg;

  localparam logic [7:0] IEC_LISTEN   = 8'h20;
  localparam logic [7:0] IEC_UNLISTEN = 8'h3F;
  localparam logic [7:0] IEC_TALK     = 8'h40;
  localparam logic [7:0] IEC_UNTALK   = 8'h5F;
  localparam logic [7:0] IEC_DATA     = 8'h60;
  localparam logic [7:0] IEC_CLOSE    = 8'hE0;
  localparam logic [7:0] IEC_OPEN     = 8'hF0;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LISTEN_WAIT = 3'd1,
    LISTEN_ACT  = 3'd2,
    TALK_WAIT   = 3'd3,
    TALK_ARMED  = 3'd4,
    TALK_ACT    = 3'd5
  } iec_state_e;

endpackage

// File: rtl/iec_fifo.sv
// iec_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset_n      : clock, synchronous active-low reset
//   i_push, i_din     : write strobe and data
//   i_pop             : read strobe (ignored when empty)
//   o_dout            : head entry (valid whenever !o_empty)
//   o_full, o_empty   : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module iec_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/iec_cmd_decoder.sv
// iec_cmd_decoder: interprets IEC bytes received under ATN as bus commands
// for one device address, tracks listener/talker role and secondary channel,
// and queues data bytes received as active listener into a channel-tagged FIFO.
//   clk, reset_n            : clock, synchronous active-low reset
//   atn, rx_byte, rx_ready  : receiver output (byte strobe + ATN level)
//   listening, talking      : current role
//   channel                 : current secondary address
//   open_pulse, close_pulse : one-cycle OPEN / CLOSE strobes
//   talk_start              : one-cycle strobe, transmitter takes the bus
//   data_byte/chan/valid    : FIFO head, popped by data_ready
//   overflow                : sticky, a byte was dropped on a full FIFO
module iec_cmd_decoder
  import iec_pkg::*;
#(
  parameter int DEVICE_ADDR = 8,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       atn,
  input  logic [7:0] rx_byte,
  input  logic       rx_ready,
  output logic       listening,
  output logic       talking,
  output logic [3:0] channel,
  output logic       open_pulse,
  output logic       close_pulse,
  output logic       talk_start,
  output logic [7:0] data_byte,
  output logic [3:0] data_chan,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overflow
);

  localparam logic [7:0] MY_LISTEN = IEC_LISTEN + 8'(DEVICE_ADDR);
  localparam logic [7:0] MY_TALK   = IEC_TALK   + 8'(DEVICE_ADDR);

  iec_state_e r_state;
  iec_state_e w_nxt;
  logic       r_listening, r_talking, r_open, r_close, r_talk_start, r_overflow;
  logic [3:0] r_channel;
  logic       w_cmd, w_dat, w_sec_ok, w_push, w_pop, w_full, w_empty;
  logic [11:0] w_head;

  assign w_cmd    = rx_ready && atn;
  assign w_dat    = rx_ready && !atn;
  assign w_sec_ok = (r_state == LISTEN_WAIT) || (r_state == TALK_WAIT);
  assign w_push   = w_dat && (r_state == LISTEN_ACT);
  assign w_pop    = data_ready && !w_empty;

  function automatic iec_state_e f_next(iec_state_e s, logic cmd, logic a,
                                        logic [7:0] b);
    logic in_listen, in_talk, sec_ok;
    in_listen = (s == LISTEN_WAIT) || (s == LISTEN_ACT);
    in_talk   = (s == TALK_WAIT) || (s == TALK_ARMED) || (s == TALK_ACT);
    sec_ok    = (s == LISTEN_WAIT) || (s == TALK_WAIT);
    f_next    = s;
    if (cmd) begin
      if (b[7:5] == 3'b001) begin
        if (b == MY_LISTEN)                    f_next = LISTEN_WAIT;
        else if (b == IEC_UNLISTEN && in_listen) f_next = IDLE;
      end else if (b[7:5] == 3'b010) begin
        // Any other talker (including UNTALK) releases our talk role.
        if (b == MY_TALK)   f_next = TALK_WAIT;
        else if (in_talk)   f_next = IDLE;
      end else if (sec_ok) begin
        if (b[7:4] == IEC_DATA[7:4])
          f_next = (s == LISTEN_WAIT) ? LISTEN_ACT : TALK_ARMED;
        else if (b[7:4] == IEC_OPEN[7:4] && s == LISTEN_WAIT)
          f_next = LISTEN_ACT;
      end
    end else if (s == TALK_ARMED && !a) begin
      f_next = TALK_ACT;
    end
  endfunction

  assign w_nxt = f_next(r_state, w_cmd, atn, rx_byte);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_channel    <= '0;
      r_listening  <= 1'b0;
      r_talking    <= 1'b0;
      r_open       <= 1'b0;
      r_close      <= 1'b0;
      r_talk_start <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_listening  <= (w_nxt == LISTEN_ACT);
      r_talking    <= (w_nxt == TALK_ARMED) || (w_nxt == TALK_ACT);
      r_open       <= 1'b0;
      r_close      <= 1'b0;
      r_talk_start <= (r_state == TALK_ARMED) && !atn;
      if (w_cmd && w_sec_ok) begin
        if (rx_byte[7:4] == IEC_DATA[7:4] || rx_byte[7:4] == IEC_CLOSE[7:4] ||
            rx_byte[7:4] == IEC_OPEN[7:4])
          r_channel <= rx_byte[3:0];
        r_close <= (rx_byte[7:4] == IEC_CLOSE[7:4]);
        r_open  <= (rx_byte[7:4] == IEC_OPEN[7:4]);
      end
      if (w_cmd && rx_byte == MY_LISTEN) r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  iec_fifo #(.WIDTH(12), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .i_push (w_push),
    .i_din  ({r_channel, rx_byte}),
    .i_pop  (data_ready),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign listening   = r_listening;
  assign talking     = r_talking;
  assign channel     = r_channel;
  assign open_pulse  = r_open;
  assign close_pulse = r_close;
  assign talk_start  = r_talk_start;
  assign overflow    = r_overflow;
  assign data_chan   = w_head[11:8];
  assign data_byte   = w_head[7:0];
  assign data_valid  = !w_empty;

endmodule

// File: doc/iec_cmd_decoder.md
# iec_cmd_decoder

Consumes the byte stream produced by the IEC serial receiver (`rx_byte`/`rx_ready` plus the bus ATN level). It interprets bytes received under ATN as IEC bus commands for one device address and tracks this device's listener/talker role and active secondary channel. It buffers data bytes received while addressed as listener in a small channel-tagged FIFO for the drive/DOS logic. It also signals the talker turnaround to the transmit side.

## Interface
- `DEVICE_ADDR`, default 8: primary address, 0–30.
- `DEPTH`, default 4: data FIFO depth; must be a power of two, at least 2.
- `clk  input  1`: system clock.
- `reset_n  input  1`: synchronous, active-low reset. One clock; all state is updated on the rising edge of `clk`.
- `atn  input  1`: 1 = ATN asserted, as decoded at the receiver input.
- `rx_byte  input  8`: received byte, LSB-first assembled by the receiver.
- `rx_ready  input  1`: one-cycle strobe; `rx_byte` is valid in the same cycle.
- `listening  output  1`: device is addressed as listener with a channel selected.
- `talking  output  1`: device is addressed as talker with a channel selected.
- `channel  output  4`: current secondary address.
- `open_pulse  output  1`: one-cycle strobe for an OPEN of `channel`.
- `close_pulse  output  1`: one-cycle strobe for a CLOSE of `channel`.
- `talk_start  output  1`: one-cycle strobe indicating the transmitter must take over the bus.
- `data_byte  output  8`: FIFO head byte.
- `data_chan  output  4`: FIFO head channel tag.
- `data_valid  output  1`: FIFO is non-empty.
- `data_ready  input  1`: consumer pop; a pop occurs when `data_valid && data_ready`.
- `overflow  output  1`: sticky flag; set when a byte is dropped because the FIFO is full.

## Operation
- A command is `rx_ready && atn`. Data is `rx_ready && !atn`.
- States: `IDLE`, `LISTEN_WAIT`, `LISTEN_ACT`, `TALK_WAIT`, `TALK_ARMED`, `TALK_ACT`.
- Primary commands, accepted in any state:
  - `0x20+DEVICE_ADDR` → `LISTEN_WAIT`. Clears `overflow`.
  - `0x20+n` with n ≠ own address → no change.
  - `0x3F` UNLISTEN → `IDLE` if in a LISTEN state.
  - `0x40+DEVICE_ADDR` → `TALK_WAIT`.
  - `0x40+n` with n ≠ own address → `IDLE` if in a TALK state. Only one talker is allowed on the bus.
  - `0x5F` UNTALK → `IDLE` if in a TALK state.
- Secondary commands are honoured only in `LISTEN_WAIT` or `TALK_WAIT`. `channel` ← `rx_byte[3:0]` in all three cases below:
  - `0x60–0x6F` DATA: `LISTEN_WAIT` → `LISTEN_ACT`; `TALK_WAIT` → `TALK_ARMED`.
  - `0xE0–0xEF` CLOSE: pulse `close_pulse`; return to the `*_WAIT` state.
  - `0xF0–0xFF` OPEN: pulse `open_pulse`; `LISTEN_WAIT` → `LISTEN_ACT` so the filename bytes that follow are queued.
  - `0x70–0xDF`: ignored.
- Any secondary command received in another state is ignored.
- Bytes `0x00–0x1F`, `0x80–0xDF` under ATN are ignored, and the state is left unchanged.
- In `TALK_ARMED`, the first cycle in which `atn` is low → `TALK_ACT`, with `talk_start` pulsed in that same transition.
- `listening` = (state == `LISTEN_ACT`). `talking` = (state ∈ {`TALK_ARMED`, `TALK_ACT`}).
- Data bytes are pushed as {`channel`, `rx_byte`} only in `LISTEN_ACT`; otherwise they are discarded.
- Push when the FIFO is full and there is no pop in the same cycle: drop the byte and set `overflow`.
- Full FIFO with a simultaneous pop and push: both are performed, and no overflow is flagged.
- Pop on an empty FIFO: no effect.
- Arithmetic: read/write pointers are log2(`DEPTH`)+1 bits and wrap naturally. Full = MSBs differ and the low bits are equal.
- Reset values:
  - State `IDLE`.
  - `channel`=0.
  - All pulses, `listening`, `talking`, `data_valid`, `overflow` = 0.
  - FIFO empty.
  - `data_byte`/`data_chan` = 0.
- Reset in mid-operation discards the FIFO contents and any pending turnaround.

## Timing
- All outputs are registered.
- State, `channel`, pulses: visible the cycle after the `rx_ready` strobe.
- Push latency: `data_valid` rises 1 cycle after `rx_ready`. `data_byte` is valid with it (first-word fall-through).
- Pop: the head advances the cycle after a pop; `data_valid` falls in that cycle if the FIFO became empty.
- `talk_start` is asserted 1 cycle after `atn` is first sampled low in `TALK_ARMED`.
- Back-to-back `rx_ready` strobes in consecutive cycles must be handled. Each byte is processed independently.

## Structure
- Shared package `iec_pkg` holds:
  - Command codes: `IEC_LISTEN`=0x20, `IEC_UNLISTEN`=0x3F, `IEC_TALK`=0x40, `IEC_UNTALK`=0x5F, `IEC_DATA`=0x60, `IEC_CLOSE`=0xE0, `IEC_OPEN`=0xF0.
  - The state encoding.
- Sub-module `iec_fifo`: synchronous FIFO with parameters `WIDTH`=12 and `DEPTH`, plus full/empty flags.

## Test plan
- LISTEN 0x28, DATA 0x62, then ATN low and bytes 0x41, 0x42 → `listening`=1, `channel`=2; FIFO pops {2,0x41} then {2,0x42}.
- LISTEN 0x28, OPEN 0xF3, then "AB" → `open_pulse` once with `channel`=3; two bytes tagged 3; UNLISTEN 0x3F → `listening`=0.
- TALK 0x48, DATA 0x60, ATN low → `talking`=1; `talk_start` pulses exactly once, 1 cycle after ATN falls.
- LISTEN 0x29 (another device), then data 0x55 → state `IDLE`, FIFO stays empty. TALK 0x48, DATA 0x60, then TALK 0x49 → `talking`=0.
- LISTEN 0x28/DATA 0x60, push 5 bytes with `DEPTH`=4 and no pops → 4 bytes are kept and `overflow`=1. A full FIFO with pop and push in the same cycle keeps count 4 with no overflow.
- `reset_n`=0 held for 1 cycle while 3 bytes are queued and talk is armed → all outputs return to 0, and no `talk_start` follows.
